// File: rtl/execution_stage.sv
// Execute stage of the in-order MIPS-style core: operand select, ALU, destination
// select and PC-relative branch target, all registered into the EX/MEM register.
module execution_stage #(
  parameter int INST_MEM_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      RegWrite,
  input  logic [1:0]                MemtoReg,
  input  logic [1:0]                ALUSrcs,
  input  logic                      ALUSrcs2,
  input  logic [3:0]                ALUOp,
  input  logic [1:0]                RegDist,
  input  logic [1:0]                Branch,
  input  logic                      MemWrite,
  input  logic                      MemRead,
  input  logic                      UARTtoReg,
  input  logic                      RegtoUART,
  input  logic [31:0]               op1_sub,
  input  logic [31:0]               op2_sub,
  input  logic [4:0]                rt,
  input  logic [4:0]                rd,
  input  logic [4:0]                sa,
  input  logic [15:0]               immediate,
  input  logic [25:0]               inst_index,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  input  logic [INST_MEM_WIDTH-1:0] pc1,
  output logic                      RegWrite_next,
  output logic [1:0]                MemtoReg_next,
  output logic [1:0]                Branch_next,
  output logic                      MemWrite_next,
  output logic                      MemRead_next,
  output logic                      UARTtoReg_next,
  output logic [31:0]               register_data,
  output logic [31:0]               alu_result,
  output logic [4:0]                rdist,
  output logic [25:0]               inst_index_next,
  output logic [INST_MEM_WIDTH-1:0] pc_next,
  output logic [INST_MEM_WIDTH-1:0] pc1_next,
  output logic [INST_MEM_WIDTH-1:0] pc2
);

  logic [31:0]               imm_sext_s;
  logic [31:0]               imm_zext_s;
  logic [31:0]               op_a_s;
  logic [31:0]               op_b_s;
  logic [31:0]               alu_d;
  logic [4:0]                rdist_d;
  logic [31:0]               reg_data_d;
  logic [31:0]               pc_sum_s;
  logic [INST_MEM_WIDTH-1:0] pc2_d;

  assign imm_sext_s = {{16{immediate[15]}}, immediate};
  assign imm_zext_s = {16'h0000, immediate};

  // Operand selection
  always_comb begin
    op_a_s = op2_sub;
    if (ALUSrcs2) begin
      op_a_s = op1_sub;
    end else begin
      op_a_s = op2_sub;
    end
    case (ALUSrcs)
      2'b00:   op_b_s = op2_sub;
      2'b01:   op_b_s = imm_sext_s;
      2'b10:   op_b_s = imm_zext_s;
      2'b11:   op_b_s = {27'd0, sa};
      default: op_b_s = 32'd0;
    endcase
  end

  // ALU; unused opcodes deliberately yield zero
  always_comb begin
    case (ALUOp)
      4'b0000: alu_d = op_a_s & op_b_s;
      4'b0001: alu_d = op_a_s | op_b_s;
      4'b0010: alu_d = op_a_s ^ op_b_s;
      4'b0011: alu_d = op_a_s + op_b_s;
      4'b0100: alu_d = op_a_s - op_b_s;
      4'b0101: alu_d = ($signed(op_a_s) < $signed(op_b_s)) ? 32'd1 : 32'd0;
      4'b0110: alu_d = (op_a_s < op_b_s) ? 32'd1 : 32'd0;
      4'b0111: alu_d = op_a_s << op_b_s[4:0];
      4'b1000: alu_d = op_a_s >> op_b_s[4:0];
      4'b1001: alu_d = $unsigned($signed(op_a_s) >>> op_b_s[4:0]);
      4'b1010: alu_d = ~(op_a_s | op_b_s);
      4'b1011: alu_d = {op_b_s[15:0], 16'h0000};
      default: alu_d = 32'd0;
    endcase
  end

  // Destination register, store data and branch target
  always_comb begin
    case (RegDist)
      2'b00:   rdist_d = rd;
      2'b01:   rdist_d = rt;
      2'b10:   rdist_d = 5'd31;
      2'b11:   rdist_d = 5'd0;
      default: rdist_d = 5'd0;
    endcase
    if (RegtoUART) begin
      reg_data_d = op1_sub;
    end else begin
      reg_data_d = op2_sub;
    end
  end

  assign pc_sum_s = {{(32-INST_MEM_WIDTH){1'b0}}, pc1} + imm_sext_s;
  assign pc2_d    = pc_sum_s[INST_MEM_WIDTH-1:0];

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      RegWrite_next   <= 1'b0;
      MemtoReg_next   <= 2'b00;
      Branch_next     <= 2'b00;
      MemWrite_next   <= 1'b0;
      MemRead_next    <= 1'b0;
      UARTtoReg_next  <= 1'b0;
      register_data   <= 32'd0;
      alu_result      <= 32'd0;
      rdist           <= 5'd0;
      inst_index_next <= 26'd0;
      pc_next         <= {INST_MEM_WIDTH{1'b0}};
      pc1_next        <= {INST_MEM_WIDTH{1'b0}};
      pc2             <= {INST_MEM_WIDTH{1'b0}};
    end else begin
      RegWrite_next   <= RegWrite;
      MemtoReg_next   <= MemtoReg;
      Branch_next     <= Branch;
      MemWrite_next   <= MemWrite;
      MemRead_next    <= MemRead;
      UARTtoReg_next  <= UARTtoReg;
      register_data   <= reg_data_d;
      alu_result      <= alu_d;
      rdist           <= rdist_d;
      inst_index_next <= inst_index;
      pc_next         <= pc;
      pc1_next        <= pc1;
      pc2             <= pc2_d;
    end
  end

endmodule

// File: tb/tb_execution_stage.sv
// Directed self-checking bench for execution_stage with hand-computed expectations.
module tb_execution_stage;
  localparam int W = 2;

  logic          clk;
  logic          rstn;
  logic          RegWrite;
  logic [1:0]    MemtoReg;
  logic [1:0]    ALUSrcs;
  logic          ALUSrcs2;
  logic [3:0]    ALUOp;
  logic [1:0]    RegDist;
  logic [1:0]    Branch;
  logic          MemWrite;
  logic          MemRead;
  logic          UARTtoReg;
  logic          RegtoUART;
  logic [31:0]   op1_sub;
  logic [31:0]   op2_sub;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [4:0]    sa;
  logic [15:0]   immediate;
  logic [25:0]   inst_index;
  logic [W-1:0]  pc;
  logic [W-1:0]  pc1;
  logic          RegWrite_next;
  logic [1:0]    MemtoReg_next;
  logic [1:0]    Branch_next;
  logic          MemWrite_next;
  logic          MemRead_next;
  logic          UARTtoReg_next;
  logic [31:0]   register_data;
  logic [31:0]   alu_result;
  logic [4:0]    rdist;
  logic [25:0]   inst_index_next;
  logic [W-1:0]  pc_next;
  logic [W-1:0]  pc1_next;
  logic [W-1:0]  pc2;

  int checks;
  int errors;

  execution_stage #(.INST_MEM_WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUSrcs(ALUSrcs), .ALUSrcs2(ALUSrcs2), .ALUOp(ALUOp), .RegDist(RegDist),
    .Branch(Branch), .MemWrite(MemWrite), .MemRead(MemRead), .UARTtoReg(UARTtoReg),
    .RegtoUART(RegtoUART), .op1_sub(op1_sub), .op2_sub(op2_sub), .rt(rt), .rd(rd),
    .sa(sa), .immediate(immediate), .inst_index(inst_index), .pc(pc), .pc1(pc1),
    .RegWrite_next(RegWrite_next), .MemtoReg_next(MemtoReg_next),
    .Branch_next(Branch_next), .MemWrite_next(MemWrite_next),
    .MemRead_next(MemRead_next), .UARTtoReg_next(UARTtoReg_next),
    .register_data(register_data), .alu_result(alu_result), .rdist(rdist),
    .inst_index_next(inst_index_next), .pc_next(pc_next), .pc1_next(pc1_next),
    .pc2(pc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Apply current inputs at the next rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".alu"},   alu_result, 32'd0);
    check({tag, ".rdata"}, register_data, 32'd0);
    check({tag, ".rdist"}, 32'(rdist), 32'd0);
    check({tag, ".ctrl"},  32'({RegWrite_next, MemtoReg_next, Branch_next,
                                MemWrite_next, MemRead_next, UARTtoReg_next}), 32'd0);
    check({tag, ".idx"},   32'(inst_index_next), 32'd0);
    check({tag, ".pcs"},   32'({pc_next, pc1_next, pc2}), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rstn = 1'b0;
    RegWrite = 1'b0; MemtoReg = 2'b00; ALUSrcs = 2'b00; ALUSrcs2 = 1'b1;
    ALUOp = 4'b0011; RegDist = 2'b00; Branch = 2'b00; MemWrite = 1'b0;
    MemRead = 1'b0; UARTtoReg = 1'b0; RegtoUART = 1'b0;
    op1_sub = 32'h0000_1010; op2_sub = 32'h0000_0101; rt = 5'd1; rd = 5'd2;
    sa = 5'd4; immediate = 16'h0101; inst_index = 26'd1; pc = 2'd1; pc1 = 2'd2;

    #2;
    check_all_zero("reset_init");
    @(negedge clk);
    rstn = 1'b1;

    // Add
    step();
    check("add.alu",   alu_result, 32'h0000_1111);
    check("add.rdist", 32'(rdist), 32'd2);
    check("add.idx",   32'(inst_index_next), 32'd1);
    check("add.pc",    32'(pc_next), 32'd1);
    check("add.pc1",   32'(pc1_next), 32'd2);
    check("add.pc2",   32'(pc2), 32'd3);
    check("add.rdata", register_data, 32'h0000_0101);
    check("add.ctrl",  32'({RegWrite_next, MemtoReg_next, Branch_next,
                            MemWrite_next, MemRead_next, UARTtoReg_next}), 32'd0);

    // Sign- vs zero-extended immediate
    ALUSrcs = 2'b01; op1_sub = 32'd5; immediate = 16'hFFFF; RegDist = 2'b01; rt = 5'd7;
    step();
    check("sext.alu",   alu_result, 32'd4);
    check("sext.rdist", 32'(rdist), 32'd7);
    ALUSrcs = 2'b10;
    step();
    check("zext.alu", alu_result, 32'h0001_0004);

    // Shifts on rt by sa
    ALUSrcs2 = 1'b0; ALUSrcs = 2'b11; op2_sub = 32'h8000_0000; sa = 5'd4;
    ALUOp = 4'b0111;
    step();
    check("sll", alu_result, 32'd0);
    ALUOp = 4'b1000;
    step();
    check("srl", alu_result, 32'h0800_0000);
    ALUOp = 4'b1001;
    step();
    check("sra", alu_result, 32'hF800_0000);

    // Compares and subtract
    ALUSrcs2 = 1'b1; ALUSrcs = 2'b00; op1_sub = 32'hFFFF_FFFF; op2_sub = 32'd1;
    ALUOp = 4'b0101;
    step();
    check("slt", alu_result, 32'd1);
    ALUOp = 4'b0110;
    step();
    check("sltu", alu_result, 32'd0);
    ALUOp = 4'b0100;
    step();
    check("sub", alu_result, 32'hFFFF_FFFE);
    ALUOp = 4'b1011; immediate = 16'h1234; ALUSrcs = 2'b10;
    step();
    check("lui", alu_result, 32'h1234_0000);
    ALUOp = 4'b1111;
    step();
    check("op1111", alu_result, 32'd0);

    // Logic ops, RegDist=11, register_data from rt
    ALUSrcs = 2'b00; op1_sub = 32'hF0F0_00FF; op2_sub = 32'h0FF0_0F0F; RegDist = 2'b11;
    rd = 5'd9; rt = 5'd12; ALUOp = 4'b0000;
    step();
    check("and",     alu_result, 32'h00F0_000F);
    check("rd0",     32'(rdist), 32'd0);
    check("rdata_rt", register_data, 32'h0FF0_0F0F);
    ALUOp = 4'b0001;
    step();
    check("or", alu_result, 32'hFFF0_0FFF);
    ALUOp = 4'b0010;
    step();
    check("xor", alu_result, 32'hFF00_0FF0);
    ALUOp = 4'b1010;
    step();
    check("nor", alu_result, 32'h000F_F000);

    // Forwarding, link register, wrapping branch target
    RegWrite = 1'b1; MemtoReg = 2'b10; Branch = 2'b11; MemWrite = 1'b1; MemRead = 1'b1;
    UARTtoReg = 1'b1; RegtoUART = 1'b1; RegDist = 2'b10;
    op1_sub = 32'hDEAD_BEEF; op2_sub = 32'h1234_5678; ALUOp = 4'b0011;
    pc = 2'd2; pc1 = 2'd3; immediate = 16'hFFFE; inst_index = 26'h2AB_CDEF;
    step();
    check("fwd.regwrite", 32'(RegWrite_next), 32'd1);
    check("fwd.memtoreg", 32'(MemtoReg_next), 32'd2);
    check("fwd.branch",   32'(Branch_next), 32'd3);
    check("fwd.memwrite", 32'(MemWrite_next), 32'd1);
    check("fwd.memread",  32'(MemRead_next), 32'd1);
    check("fwd.uart",     32'(UARTtoReg_next), 32'd1);
    check("fwd.rdist",    32'(rdist), 32'd31);
    check("fwd.rdata",    register_data, 32'hDEAD_BEEF);
    check("fwd.alu",      alu_result, 32'hF0E2_1567);
    check("fwd.idx",      32'(inst_index_next), 32'h2AB_CDEF);
    check("fwd.pc",       32'(pc_next), 32'd2);
    check("fwd.pc2",      32'(pc2), 32'd1);

    // Asynchronous reset mid-cycle, outputs held at zero until an edge after release
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("reset_async");
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_all_zero("reset_hold");
    step();
    check("post_reset.alu", alu_result, 32'hF0E2_1567);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/execution_stage.md
Name: execution_stage

Overview:
- Execute (EX) stage of the in-order MIPS-style core, placed between decode and memory access.
- Selects ALU operands, performs the 4-bit-coded ALU operation and picks the destination register.
- Computes the PC-relative branch target.
- Registers all results and forwarded control signals into the EX/MEM pipeline register, 1-cycle latency.

Parameters:
- INST_MEM_WIDTH, 2: width of the word-addressed instruction-memory PC fields (pc, pc1, pc_next, pc1_next, pc2).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- RegWrite  in  1  register-file write enable, forwarded.
- MemtoReg  in  2  write-back source select, forwarded.
- ALUSrcs  in  2  ALU operand-B select.
- ALUSrcs2  in  1  ALU operand-A select.
- ALUOp  in  4  ALU operation code.
- RegDist  in  2  destination register select.
- Branch  in  2  branch/jump kind, forwarded.
- MemWrite  in  1  store enable, forwarded.
- MemRead  in  1  load enable, forwarded.
- UARTtoReg  in  1  UART-receive-to-register, forwarded.
- RegtoUART  in  1  selects UART data source for register_data.
- op1_sub  in  32  rs register value.
- op2_sub  in  32  rt register value.
- rt  in  5  rt field.
- rd  in  5  rd field.
- sa  in  5  shift amount field.
- immediate  in  16  immediate field.
- inst_index  in  26  jump target field.
- pc  in  INST_MEM_WIDTH  PC of the instruction.
- pc1  in  INST_MEM_WIDTH  pc+1.
- RegWrite_next, MemtoReg_next(2), Branch_next(2), MemWrite_next, MemRead_next, UARTtoReg_next  out  registered copies of the corresponding inputs.
- register_data  out  32  store/UART data.
- alu_result  out  32  ALU output.
- rdist  out  5  destination register number.
- inst_index_next  out  26  registered inst_index.
- pc_next  out  INST_MEM_WIDTH  registered pc.
- pc1_next  out  INST_MEM_WIDTH  registered pc1.
- pc2  out  INST_MEM_WIDTH  branch target.

Behaviour:
- Every output is a flop updated on rising clk. Latency is exactly 1 cycle. No stall or flush; the stage accepts new inputs every cycle.
- rstn low clears every output to 0 immediately and asynchronously, independent of clk. Outputs remain 0 until the first rising edge after rstn rises.
- Operand A: ALUSrcs2=1 selects op1_sub; ALUSrcs2=0 selects op2_sub (shift source).
- Operand B by ALUSrcs:
  - 00: op2_sub
  - 01: sign-extended immediate
  - 10: zero-extended immediate
  - 11: zero-extended sa
- ALUOp codes (32-bit, wrap-around, no overflow trap):
  - 0000 A&B, 0001 A|B, 0010 A^B, 0011 A+B, 0100 A-B
  - 0101 signed A<B ? 1 : 0, 0110 unsigned A<B ? 1 : 0
  - 0111 A<<B[4:0], 1000 logical A>>B[4:0], 1001 arithmetic A>>>B[4:0]
  - 1010 ~(A|B), 1011 B<<16 (lui)
  - 1100–1111 produce 0
- rdist by RegDist: 00 rd, 01 rt, 10 5'd31 (link), 11 5'd0.
- register_data = op1_sub when RegtoUART=1, else op2_sub.
- pc2 = pc1 + sign-extended immediate, truncated to INST_MEM_WIDTH bits (wraps modulo 2^INST_MEM_WIDTH).
- Branch decisions are made downstream from Branch_next and alu_result; the stage computes no flags.
- Forwarded control, inst_index, pc and pc1 are passed unmodified.
- Simultaneous reset and clock edge: reset wins.

Test Plan:
- Reset: drive rstn=0 mid-operation with arbitrary inputs -> all outputs 0 immediately, without waiting for a clock edge.
- Add: ALUSrcs=00, ALUSrcs2=1, ALUOp=0011, RegDist=00, op1_sub=0x00001010, op2_sub=0x00000101, rt=1, rd=2, sa=4, immediate=0x0101, inst_index=1, pc=1, pc1=2, controls 0 -> after one edge: alu_result=0x00001111, rdist=2, inst_index_next=1, pc_next=1, pc1_next=2, pc2=3, register_data=0x00000101, all *_next=0.
- Immediate/sign: ALUSrcs=01, ALUOp=0011, op1_sub=5, immediate=0xFFFF, RegDist=01, rt=7 -> alu_result=4, rdist=7. Same inputs with ALUSrcs=10 -> alu_result=0x00010004.
- Shifts: ALUSrcs2=0, ALUSrcs=11, op2_sub=0x80000000, sa=4 -> ALUOp 0111 gives 0, 1000 gives 0x08000000, 1001 gives 0xF8000000.
- Compare/misc: op1_sub=0xFFFFFFFF, op2_sub=1 -> ALUOp 0101 gives 1, 0110 gives 0, 0100 gives 0xFFFFFFFE. ALUOp 1011 with immediate=0x1234, ALUSrcs=10 gives 0x12340000. ALUOp 1111 gives 0.
- Forwarding/link: RegWrite=1, MemtoReg=10, Branch=11, MemWrite=1, MemRead=1, UARTtoReg=1, RegtoUART=1, RegDist=10 -> same values on the *_next outputs, rdist=31, register_data=op1_sub. pc1=3, immediate=0xFFFE -> pc2=1.
